// File: rtl/vc_pkg.sv
//------------------------------------------------------------------------------
// Module      : vc_pkg
// Description : Shared state encoding and width helpers for the victim-cache
//               tag store.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EVICT       = 2'd1,
    FLUSH_SCAN  = 2'd2,
    FLUSH_EVICT = 2'd3
  } vc_state_e;

  function automatic int way_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int occ_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vc_lru_ages.sv
//------------------------------------------------------------------------------
// Module      : vc_lru_ages
// Description : True-LRU age registers (0 = MRU) with touch/insert/remove
//               updates and victim selection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vc_lru_ages #(
  parameter int NUM_WAYS = 8,
  parameter int WAY_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_WAYS-1:0] valid,
  input  logic                touch_en,
  input  logic [WAY_W-1:0]    touch_way,
  input  logic                remove_en,
  input  logic [WAY_W-1:0]    remove_way,
  input  logic                insert_en,
  input  logic [WAY_W-1:0]    insert_way,
  output logic [WAY_W-1:0]    victim_way,
  output logic                full
);

  localparam logic [WAY_W-1:0] c_oldest = WAY_W'(NUM_WAYS - 1);

  logic [WAY_W-1:0] r_age [NUM_WAYS];
  logic [WAY_W-1:0] w_touch_age;
  logic [WAY_W-1:0] w_remove_age;

  assign w_touch_age  = r_age[touch_way];
  assign w_remove_age = r_age[remove_way];
  assign full         = &valid;

  // Valid ways always hold a permutation of 0..occupancy-1, so every update
  // only shifts the ages on one side of the affected way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WAYS; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (insert_en) begin
          if (insert_way == WAY_W'(i))
            r_age[i] <= '0;
          else if (valid[i])
            r_age[i] <= r_age[i] + 1'b1;
        end else if (touch_en) begin
          if (touch_way == WAY_W'(i))
            r_age[i] <= '0;
          else if (valid[i] && (r_age[i] < w_touch_age))
            r_age[i] <= r_age[i] + 1'b1;
        end else if (remove_en && valid[i] && (r_age[i] > w_remove_age)) begin
          r_age[i] <= r_age[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!valid[i]) victim_way = WAY_W'(i);
    if (full) begin
      for (int i = 0; i < NUM_WAYS; i++)
        if (r_age[i] == c_oldest) victim_way = WAY_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vc_tag_lru_store.sv
//------------------------------------------------------------------------------
// Module      : vc_tag_lru_store
// Description : Fully-associative victim-cache tag store with registered
//               lookup, true-LRU allocate, dirty eviction port and flush walk.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vc_tag_lru_store
  import vc_pkg::*;
#(
  parameter int  TAG_WIDTH = 26,
  parameter int  NUM_WAYS  = 8,
  localparam int WAY_W     = way_w(NUM_WAYS),
  localparam int OCC_W     = occ_w(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lkp_valid,
  output logic                 lkp_ready,
  input  logic [TAG_WIDTH-1:0] lkp_tag,
  input  logic                 lkp_inval,
  output logic                 lkp_resp_valid,
  output logic                 lkp_hit,
  output logic [WAY_W-1:0]     lkp_way,
  output logic                 lkp_dirty,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 alloc_dirty,
  output logic                 alloc_done,
  output logic [WAY_W-1:0]     alloc_way,
  output logic                 evict_valid,
  input  logic                 evict_ready,
  output logic [TAG_WIDTH-1:0] evict_tag,
  output logic [WAY_W-1:0]     evict_way,
  input  logic                 dirty_set_en,
  input  logic [WAY_W-1:0]     dirty_set_way,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [OCC_W-1:0]     occupancy
);

  localparam logic [WAY_W-1:0] c_last_way = WAY_W'(NUM_WAYS - 1);

  vc_state_e r_state;
  vc_state_e w_state_nxt;

  logic [NUM_WAYS-1:0]  r_valid;
  logic [NUM_WAYS-1:0]  r_dirty;
  logic [TAG_WIDTH-1:0] r_tag [NUM_WAYS];
  logic [WAY_W-1:0]     r_scan;
  logic [TAG_WIDTH-1:0] r_pend_tag;
  logic                 r_pend_dirty;
  logic [TAG_WIDTH-1:0] r_evict_tag;
  logic [WAY_W-1:0]     r_evict_way;
  logic                 r_lkp_resp_valid;
  logic                 r_lkp_hit;
  logic [WAY_W-1:0]     r_lkp_way;
  logic                 r_lkp_dirty;
  logic                 r_alloc_done;
  logic [WAY_W-1:0]     r_alloc_way;
  logic                 r_flush_done;

  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic [WAY_W-1:0]     w_victim;
  logic                 w_full;
  logic                 w_lkp_fire;
  logic                 w_alloc_fire;
  logic                 w_touch_en;
  logic                 w_inv_en;
  logic [WAY_W-1:0]     w_inv_way;
  logic                 w_remove_en;
  logic                 w_write_en;
  logic [WAY_W-1:0]     w_write_way;
  logic [TAG_WIDTH-1:0] w_write_tag;
  logic                 w_write_dirty;
  logic                 w_cap_en;
  logic [WAY_W-1:0]     w_cap_way;
  logic                 w_dirty_set_ok;
  logic                 w_flush_start;
  logic                 w_scan_step;
  logic                 w_flush_fin;

  // Lowest index wins if a caller ever lets two ways hold the same tag.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == lkp_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_WAYS; i++) occupancy = occupancy + OCC_W'(r_valid[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    lkp_ready      = 1'b0;
    alloc_ready    = 1'b0;
    evict_valid    = 1'b0;
    flush_busy     = 1'b0;
    w_lkp_fire     = 1'b0;
    w_alloc_fire   = 1'b0;
    w_touch_en     = 1'b0;
    w_inv_en       = 1'b0;
    w_inv_way      = w_hit_way;
    w_write_en     = 1'b0;
    w_write_way    = w_victim;
    w_write_tag    = alloc_tag;
    w_write_dirty  = alloc_dirty;
    w_cap_en       = 1'b0;
    w_cap_way      = w_victim;
    w_dirty_set_ok = 1'b0;
    w_flush_start  = 1'b0;
    w_scan_step    = 1'b0;
    w_flush_fin    = 1'b0;
    case (r_state)
      IDLE: begin
        lkp_ready    = !flush_req;
        alloc_ready  = !flush_req && !lkp_valid;
        w_lkp_fire   = lkp_valid && !flush_req;
        w_alloc_fire = alloc_valid && !flush_req && !lkp_valid;
        if (flush_req) begin
          w_state_nxt   = FLUSH_SCAN;
          w_flush_start = 1'b1;
        end
        if (w_lkp_fire && w_hit) begin
          w_inv_en   = lkp_inval;
          w_touch_en = !lkp_inval;
        end
        w_dirty_set_ok = dirty_set_en && r_valid[dirty_set_way] &&
                         !(w_inv_en && (w_inv_way == dirty_set_way));
        // A valid victim only exists when the store is full.
        if (w_alloc_fire) begin
          if (w_full && r_dirty[w_victim]) begin
            w_cap_en    = 1'b1;
            w_state_nxt = EVICT;
          end else begin
            w_write_en = 1'b1;
          end
        end
      end
      EVICT: begin
        evict_valid = 1'b1;
        if (evict_ready) begin
          w_write_en    = 1'b1;
          w_write_way   = r_evict_way;
          w_write_tag   = r_pend_tag;
          w_write_dirty = r_pend_dirty;
          w_state_nxt   = IDLE;
        end
      end
      FLUSH_SCAN: begin
        flush_busy = 1'b1;
        w_cap_way  = r_scan;
        if (r_valid[r_scan] && r_dirty[r_scan]) begin
          w_cap_en    = 1'b1;
          w_state_nxt = FLUSH_EVICT;
        end else begin
          w_inv_en    = 1'b1;
          w_inv_way   = r_scan;
          w_scan_step = 1'b1;
        end
      end
      FLUSH_EVICT: begin
        flush_busy  = 1'b1;
        evict_valid = 1'b1;
        if (evict_ready) begin
          w_inv_en    = 1'b1;
          w_inv_way   = r_scan;
          w_scan_step = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_scan_step) begin
      if (r_scan == c_last_way) begin
        w_flush_fin = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = FLUSH_SCAN;
      end
    end
  end

  assign w_remove_en = w_inv_en && r_valid[w_inv_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid          <= '0;
      r_dirty          <= '0;
      for (int i = 0; i < NUM_WAYS; i++) r_tag[i] <= '0;
      r_scan           <= '0;
      r_pend_tag       <= '0;
      r_pend_dirty     <= 1'b0;
      r_evict_tag      <= '0;
      r_evict_way      <= '0;
      r_lkp_resp_valid <= 1'b0;
      r_lkp_hit        <= 1'b0;
      r_lkp_way        <= '0;
      r_lkp_dirty      <= 1'b0;
      r_alloc_done     <= 1'b0;
      r_alloc_way      <= '0;
      r_flush_done     <= 1'b0;
    end else begin
      r_lkp_resp_valid <= w_lkp_fire;
      r_lkp_hit        <= w_lkp_fire && w_hit;
      r_lkp_way        <= (w_lkp_fire && w_hit) ? w_hit_way : '0;
      r_lkp_dirty      <= w_lkp_fire && w_hit && r_dirty[w_hit_way];
      r_alloc_done     <= w_write_en;
      r_flush_done     <= w_flush_fin;
      if (w_write_en) r_alloc_way <= w_write_way;
      if (w_dirty_set_ok) r_dirty[dirty_set_way] <= 1'b1;
      if (w_inv_en) begin
        r_valid[w_inv_way] <= 1'b0;
        r_dirty[w_inv_way] <= 1'b0;
      end
      if (w_write_en) begin
        r_tag[w_write_way]   <= w_write_tag;
        r_valid[w_write_way] <= 1'b1;
        r_dirty[w_write_way] <= w_write_dirty;
      end
      if (w_cap_en) begin
        r_evict_tag  <= r_tag[w_cap_way];
        r_evict_way  <= w_cap_way;
        r_pend_tag   <= alloc_tag;
        r_pend_dirty <= alloc_dirty;
      end
      if (w_flush_start)
        r_scan <= '0;
      else if (w_scan_step && (r_scan != c_last_way))
        r_scan <= r_scan + 1'b1;
    end
  end

  vc_lru_ages #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (r_valid),
    .touch_en   (w_touch_en),
    .touch_way  (w_hit_way),
    .remove_en  (w_remove_en),
    .remove_way (w_inv_way),
    .insert_en  (w_write_en),
    .insert_way (w_write_way),
    .victim_way (w_victim),
    .full       (w_full)
  );

  assign lkp_resp_valid = r_lkp_resp_valid;
  assign lkp_hit        = r_lkp_hit;
  assign lkp_way        = r_lkp_way;
  assign lkp_dirty      = r_lkp_dirty;
  assign alloc_done     = r_alloc_done;
  assign alloc_way      = r_alloc_way;
  assign evict_tag      = r_evict_tag;
  assign evict_way      = r_evict_way;
  assign flush_done     = r_flush_done;

endmodule

`default_nettype wire

// File: doc/vc_tag_lru_store.md
Name: vc_tag_lru_store

Overview:
- Fully-associative victim-cache tag store, successor to the basic tag store.
- Adds a registered lookup response, true-LRU age tracking, and victim selection on allocate.
- A dirty victim is handed off through a valid/ready eviction port; a full-store flush walks every way.
- Sits between the L1 miss path (lookup/allocate requests) and the writeback path (eviction port).

Parameters:
TAG_WIDTH, 26, tag bits stored per way
NUM_WAYS, 8, number of ways; power of two, >= 2; WAY_W = $clog2(NUM_WAYS), OCC_W = $clog2(NUM_WAYS+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
lkp_valid  in  1  lookup request
lkp_ready  out  1  lookup accepted when lkp_valid & lkp_ready
lkp_tag  in  TAG_WIDTH  lookup tag
lkp_inval  in  1  on hit, invalidate the hit way (line returns to L1)
lkp_resp_valid  out  1  registered lookup response strobe
lkp_hit  out  1  hit flag
lkp_way  out  WAY_W  hit way
lkp_dirty  out  1  dirty bit of the hit way before any invalidate
alloc_valid  in  1  allocate request
alloc_ready  out  1  allocate accepted on handshake
alloc_tag  in  TAG_WIDTH  tag to insert
alloc_dirty  in  1  initial dirty bit of the inserted line
alloc_done  out  1  one-cycle pulse when the tag has been written
alloc_way  out  WAY_W  way written; valid with alloc_done
evict_valid  out  1  dirty line being evicted
evict_ready  in  1  writeback path accepts the eviction
evict_tag  out  TAG_WIDTH  evicted tag
evict_way  out  WAY_W  evicted way
dirty_set_en  in  1  mark a way dirty
dirty_set_way  in  WAY_W  way to mark dirty
flush_req  in  1  start a flush
flush_busy  out  1  high while a flush is in progress
flush_done  out  1  one-cycle pulse when the flush completes
occupancy  out  OCC_W  number of valid ways

Behaviour:
- FSM states: IDLE, EVICT, FLUSH_SCAN, FLUSH_EVICT. Reset state is IDLE.
- Reset clears all valid, dirty and age state.
- Output reset values: all registered outputs 0, occupancy 0. lkp_ready = alloc_ready = 1 after reset, unless flush_req is high.
- Ready and priority rules:
  - lkp_ready = IDLE & !flush_req.
  - alloc_ready = IDLE & !flush_req & !lkp_valid.
  - Resulting priority: flush > lookup > alloc.
- Lookup:
  - Compare lkp_tag against all valid ways in the accept cycle N.
  - lkp_resp_valid/hit/way/dirty are registered and appear at N+1 for exactly one cycle.
  - Hit way is the lowest index on a multi-hit. Multi-hit is a caller error; the bench asserts it never happens.
- LRU ages: one WAY_W-bit age per way; 0 = MRU. Valid ways always hold the unique ages 0..occupancy-1.
  - Touch (hit, no inval) at N edge: valid ways with age < hit age increment; hit way age becomes 0.
  - Hit with lkp_inval at N edge: clear valid and dirty; valid ways with age > hit age decrement; occupancy decrements. No touch.
- Allocate (accepted at cycle N):
  - Victim = lowest-index invalid way. If the store is full, victim = the way with age NUM_WAYS-1.
  - Victim invalid or clean: at the N edge write tag, valid=1, dirty=alloc_dirty; new way age 0, all other valid ways increment. alloc_done/alloc_way pulse at N+1.
  - Victim valid and dirty: register evict_tag/evict_way and go to EVICT. evict_valid holds, with stable data, until evict_ready.
  - On the evict handshake edge, perform the write as above and return to IDLE. alloc_done pulses the following cycle.
  - occupancy increments only when the victim was invalid.
- dirty_set_en: honoured only in IDLE and only on a valid way; ignored otherwise. In the same cycle as a lookup invalidate of the same way, the invalidate wins.
- Flush:
  - Accepted in IDLE. flush_busy goes high next cycle.
  - FLUSH_SCAN checks one way per cycle, index 0..NUM_WAYS-1.
  - Valid and dirty way: go to FLUSH_EVICT, present it on the evict port, wait for evict_ready.
  - Every scanned way is invalidated (on the evict handshake for dirty ways).
  - After the last way: flush_done pulses, flush_busy drops, state returns to IDLE, occupancy = 0.
  - Minimum flush duration is NUM_WAYS cycles.
- Asynchronous reset mid-EVICT or mid-flush: abandon the operation, all state cleared, evict_valid drops immediately. No alloc_done or flush_done pulse.

Decomposition:
- Package vc_pkg: vc_state_e enum (IDLE, EVICT, FLUSH_SCAN, FLUSH_EVICT) and the WAY_W/OCC_W helper functions.
- Sub-module vc_lru_ages: holds the age registers and performs touch/insert/remove updates. Outputs victim_way and full.

Test Plan (NUM_WAYS=4, TAG_WIDTH=8):
- Reset, then alloc tags 0x10,0x11,0x12,0x13 (clean) -> alloc_way 0,1,2,3, each alloc_done one cycle after accept; occupancy=4.
- Lookup 0x10, then alloc 0x20 -> lkp_hit=1, way 0 at N+1; victim is way 1 (LRU), alloc_way=1, no evict_valid.
- dirty_set way 2; touch ways 3,0,1; alloc 0x30 -> evict_valid with tag 0x12, way 2. Hold evict_ready=0 for 3 cycles: alloc_ready=0 and outputs stable. Release -> alloc_done pulses next cycle, alloc_way=2.
- Lookup 0x13 with lkp_inval -> hit, way 3; occupancy 4->3; a following alloc picks way 3 with no eviction.
- Simultaneous flush_req, lkp_valid and alloc_valid -> only the flush is accepted. Two dirty ways produce exactly 2 eviction handshakes in index order; flush_done pulses, occupancy=0, a subsequent lookup misses.
- Assert rst_n low during EVICT -> evict_valid=0 immediately, no alloc_done pulse; after release lkp_ready=1 and occupancy=0.
